// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO: any depth >= 2, programmable almost thresholds, sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through; otherwise read_data is registered per pop.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              write,
  input  logic [DATA_WIDTH-1:0]             write_data,
  input  logic                              read,
  output logic [DATA_WIDTH-1:0]             read_data,
  output logic                              read_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill_level,
  output logic                              full,
  output logic                              empty,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic                              overflow,
  output logic                              underflow,
  input  logic                              err_clr
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL  = CNT_W'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fill_q, fill_d;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  read_cmd_c, write_cmd_c;

  // A write at full is only taken when a pop frees the slot in the same cycle.
  assign read_cmd_c  = read & ~empty_q;
  assign write_cmd_c = write & (~full_q | read_cmd_c);

  // Pointer, level and error-flag next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ovf_d    = (write & ~write_cmd_c) | (ovf_q & ~err_clr);
    udf_d    = (read & empty_q) | (udf_q & ~err_clr);
    if (write_cmd_c) begin
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (read_cmd_c) begin
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({write_cmd_c, read_cmd_c})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Control state; status flags are registered from the next fill level
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      full_q   <= (fill_d == CNT_MAX);
      empty_q  <= (fill_d == '0);
      afull_q  <= (fill_d >= AF_LVL);
      aempty_q <= (fill_d <= AE_LVL);
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (write_cmd_c) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head entry is always presented; read pops it.
  assign read_data  = mem_q[rd_ptr_q];
  assign read_valid = ~empty_q;
`else
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= read_cmd_c;
      if (read_cmd_c) begin
        rdata_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign read_data  = rdata_q;
  assign read_valid = rvalid_q;
`endif

  assign fill_level   = fill_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Synchronous single-clock FIFO, the parametrised successor to the team's power-of-2 register FIFO. Supports any depth ≥ 2, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a registered read port with a read-valid strobe, and an optional first-word-fall-through (FWFT) mode. It is used as the general buffering element between streaming blocks in the datapath.

## Interface
- DATA_WIDTH, 8, word width in bits (≥ 1)
- FIFO_DEPTH, 16, number of entries; any integer ≥ 2, power of 2 not required
- AFULL_THRESH, FIFO_DEPTH-2, almost_full asserts when fill_level ≥ this value (1..FIFO_DEPTH)
- AEMPTY_THRESH, 2, almost_empty asserts when fill_level ≤ this value (0..FIFO_DEPTH-1)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- write  in  1  write request
- write_data  in  DATA_WIDTH  write word
- read  in  1  read (pop) request
- read_data  out  DATA_WIDTH  read word
- read_valid  out  1  read_data qualifier (mode-dependent, see Configuration)
- fill_level  out  $clog2(FIFO_DEPTH+1)  stored entries, 0..FIFO_DEPTH inclusive
- full  out  1  fill_level == FIFO_DEPTH
- empty  out  1  fill_level == 0
- almost_full  out  1  fill_level ≥ AFULL_THRESH
- almost_empty  out  1  fill_level ≤ AEMPTY_THRESH
- overflow  out  1  sticky: write attempted and rejected
- underflow  out  1  sticky: read attempted while empty
- err_clr  in  1  clears overflow/underflow

## Operation
- Accepted read: read_cmd = read & ~empty.
- Accepted write: write_cmd = write & (~full | read_cmd); a write while full is accepted only if a read is accepted in the same cycle.
- Write to empty FIFO with simultaneous read: read rejected (no bypass); the write is stored.
- Pointers: write_ptr and read_ptr are $clog2(FIFO_DEPTH) bits wide and advance by 1 on their command. They wrap explicitly from FIFO_DEPTH-1 to 0; no reliance on natural binary wrap.
- fill_level: +1 on write_cmd only, -1 on read_cmd only, unchanged on both or neither. It never leaves 0..FIFO_DEPTH.
- full, empty, almost_full and almost_empty are decoded from the registered fill_level (no combinational path from write/read).
- overflow is set when write & ~write_cmd; underflow is set when read & empty.
- Both error flags are cleared by err_clr. If a set condition and err_clr occur in the same cycle, set wins.
- Error events do not alter pointers, fill_level or storage.
- Storage array is not reset; contents are undefined until written.
- Reset values: pointers 0, fill_level 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, read_data 0, read_valid 0 (standard mode).
- Reset mid-operation discards all contents; the first cycle after rst deasserts behaves as after power-up.

## Timing
- Write latency: a word written in cycle N is visible in fill_level/flags in N+1 and is readable from cycle N+1.
- Standard mode read: a read_cmd in cycle N loads read_data from the read_ptr entry at the N→N+1 edge. read_valid is 1 during N+1 only. read_data holds its last value otherwise.
- Back-to-back reads deliver one word per cycle; read_valid stays high continuously.
- Error flags register one cycle after the offending request.

## Configuration
- FIFO_FWFT_EN undefined (standard mode): behaviour as in Timing, with a registered read_data and a one-cycle read_valid pulse per accepted read.
- FIFO_FWFT_EN defined (FWFT mode): the head entry is presented on read_data with read_valid = ~empty. read acts as an acknowledge/pop: the next entry appears in the following cycle.
- In FWFT mode, a word written into an empty FIFO in cycle N appears with read_valid = 1 in N+1.
- In FWFT mode read_data is don't-care while read_valid = 0, and read_valid is 0 in reset.
- All flags, fill_level and error logic are identical in both modes.

## Test plan
- Reset then idle: after rst, check empty=1, almost_empty=1, fill_level=0, full=0, overflow=0, underflow=0, read_valid=0.
- Fill and drain (DEPTH=5): write 1..5, so full=1 and fill_level=5. Read 5× and require 1..5 in order, then empty=1. Repeat 3× to exercise pointer wrap 4→0.
- Full with simultaneous write+read (DEPTH=5): write 0xAA with read accepted; fill_level stays 5, overflow stays 0, and 0xAA is read last.
- Errors: write at full sets overflow=1 with fill_level unchanged; read at empty sets underflow=1. err_clr clears both, and err_clr coincident with a new overflow leaves overflow=1.
- Thresholds (DEPTH=16, AFULL=14, AEMPTY=2): almost_full rises on the cycle fill_level reaches 14; almost_empty falls when fill_level reaches 3.
- Mode latency: write 0x5A into an empty FIFO. Standard mode: read_data=0x5A with read_valid=1 exactly one cycle after the read. FWFT mode: read_data=0x5A and read_valid=1 one cycle after the write, with no read. Then assert rst mid-stream and require empty=1 on the next cycle.
